draw_layer_scheduler: RTL

//  Frame scheduler that shares the single DrawMif sprite-draw engine between NUM_LAYERS layer requesters.
//  On each frame tick it pulses the sprite updater, then issues one draw per enabled layer in ascending index order
//  (layer 0 = background, painter's order), running the engine's draw/ready handshake for each.

---
 rtl/draw_layer_scheduler_pkg.sv | 37 +++
 rtl/draw_layer_scheduler_if.sv | 27 ++
 rtl/draw_layer_scheduler_next_layer_finder.sv | 24 ++
 rtl/draw_layer_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/draw_layer_scheduler_pkg.sv
// Shared types, widths and packed-bus slice helpers for the draw layer scheduler.
package draw_layer_scheduler_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned ROM_W = 4;
  localparam int unsigned OVR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_SELECT = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Snapshot of one layer's draw parameters as presented to the engine.
  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [ROM_W-1:0] rom;
  } layer_desc_t;

  // Low bit of layer i within the packed requester buses.
  function automatic int unsigned x_lo(input int unsigned layer);
    return layer * X_W;
  endfunction

  function automatic int unsigned y_lo(input int unsigned layer);
    return layer * Y_W;
  endfunction

  function automatic int unsigned rom_lo(input int unsigned layer);
    return layer * ROM_W;
  endfunction

endpackage

// File: rtl/draw_layer_scheduler_if.sv
// Draw/ready handshake and sprite origin bundle between scheduler and DrawMif engine.
interface draw_layer_scheduler_if;
  import draw_layer_scheduler_pkg::*;

  logic             draw;
  logic             ready;
  logic [X_W-1:0]   x_origin;
  logic [Y_W-1:0]   y_origin;
  logic [ROM_W-1:0] rom_id;

  modport master (
    output draw,
    output x_origin,
    output y_origin,
    output rom_id,
    input  ready
  );

  modport slave (
    input  draw,
    input  x_origin,
    input  y_origin,
    input  rom_id,
    output ready
  );

endinterface

// File: rtl/draw_layer_scheduler_next_layer_finder.sv
// Combinational search for the lowest enabled layer at or above start_idx.
module draw_layer_scheduler_next_layer_finder #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned IDX_W      = $clog2(NUM_LAYERS) + 1
) (
  input  logic [NUM_LAYERS-1:0] enable,
  input  logic [IDX_W-1:0]      start_idx,
  output logic                  found,
  output logic [IDX_W-1:0]      index
);

  // Scan downward so the last hit written is the lowest qualifying layer.
  always_comb begin
    found = 1'b0;
    index = IDX_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (enable[i] && (IDX_W'(i) >= start_idx)) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/draw_layer_scheduler.sv
// Per-frame arbiter sharing the DrawMif engine between layer requesters in painter's order.
module draw_layer_scheduler
  import draw_layer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = 4,
  parameter int unsigned UPDATE_CYCLES  = 21,
  parameter int unsigned READY_DELAY    = 21,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_tick,
  input  logic [NUM_LAYERS-1:0]       layer_enable,
  input  logic [NUM_LAYERS*X_W-1:0]   layer_x,
  input  logic [NUM_LAYERS*Y_W-1:0]   layer_y,
  input  logic [NUM_LAYERS*ROM_W-1:0] layer_rom,
  draw_layer_scheduler_if.master      eng,
  output logic                        sprite_update,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        timeout_err,
  output logic [OVR_W-1:0]            overrun_count
);

  localparam int unsigned IDX_W = $clog2(NUM_LAYERS) + 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               tick_hold_q, tick_hold_d;
  logic               draw_q, draw_d;
  layer_desc_t        desc_q, desc_d;
  logic               sprite_update_q, sprite_update_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               timeout_err_q, timeout_err_d;
  logic [OVR_W-1:0]   overrun_q, overrun_d;

  logic               tick_edge;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  layer_desc_t        sel_desc;

  assign tick_edge = frame_tick & ~tick_hold_q;

  draw_layer_scheduler_next_layer_finder #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_finder (
    .enable    (layer_enable),
    .start_idx (idx_q),
    .found     (sel_found),
    .index     (sel_idx)
  );

  // Mux the chosen layer's origin and ROM id out of the packed requester buses.
  always_comb begin
    sel_desc = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (sel_idx == IDX_W'(i)) begin
        sel_desc.x   = layer_x[x_lo(i) +: X_W];
        sel_desc.y   = layer_y[y_lo(i) +: Y_W];
        sel_desc.rom = layer_rom[rom_lo(i) +: ROM_W];
      end
    end
  end

  // Next-state and next-output logic for the frame sequence.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    count_d         = count_q;
    tick_hold_d     = frame_tick;
    draw_d          = draw_q;
    desc_d          = desc_q;
    sprite_update_d = sprite_update_q;
    frame_done_d    = 1'b0;
    timeout_err_d   = timeout_err_q;
    overrun_d       = overrun_q;

    // A tick edge that arrives mid-frame is dropped but counted.
    if (tick_edge && (state_q != ST_IDLE) && (overrun_q != '1)) begin
      overrun_d = overrun_q + OVR_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (tick_edge) begin
          state_d         = ST_UPDATE;
          count_d         = '0;
          idx_d           = '0;
          sprite_update_d = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (count_q == CNT_W'(UPDATE_CYCLES - 1)) begin
          sprite_update_d = 1'b0;
          count_d         = '0;
          state_d         = ST_SELECT;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_SELECT: begin
        if (sel_found) begin
          desc_d  = sel_desc;
          idx_d   = sel_idx;
          draw_d  = 1'b1;
          count_d = '0;
          state_d = ST_ISSUE;
        end else begin
          frame_done_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_ISSUE: begin
        // Ready is only trusted once the engine has had time to drop it.
        if ((count_q >= CNT_W'(READY_DELAY - 1)) && eng.ready) begin
          draw_d  = 1'b0;
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SELECT;
        end else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          draw_d        = 1'b0;
          timeout_err_d = 1'b1;
          idx_d         = idx_q + IDX_W'(1);
          state_d       = ST_SELECT;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; a high tick at reset release must not start a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      count_q         <= '0;
      tick_hold_q     <= 1'b1;
      draw_q          <= 1'b0;
      desc_q          <= '0;
      sprite_update_q <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      timeout_err_q   <= 1'b0;
      overrun_q       <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      count_q         <= count_d;
      tick_hold_q     <= tick_hold_d;
      draw_q          <= draw_d;
      desc_q          <= desc_d;
      sprite_update_q <= sprite_update_d;
      busy_q          <= busy_d;
      frame_done_q    <= frame_done_d;
      timeout_err_q   <= timeout_err_d;
      overrun_q       <= overrun_d;
    end
  end

  assign eng.draw      = draw_q;
  assign eng.x_origin  = desc_q.x;
  assign eng.y_origin  = desc_q.y;
  assign eng.rom_id    = desc_q.rom;
  assign sprite_update = sprite_update_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign timeout_err   = timeout_err_q;
  assign overrun_count = overrun_q;

endmodule
